program_sequencer: RTL
======================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program-counter and operand width in bits.
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address entries (power of two, >=2).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 stall  in  1  when 1, hold all state (PC, operand_q, stack, call_armed).
REQ-006 prog_addr  out  PC_W  program memory address, equal to the PC register.
REQ-007 prog_data  in  4+PC_W  combinational memory word: [PC_W+3:PC_W] = opcode, [PC_W-1:0] = operand.
REQ-008 instruction  out  instruction_t (4)  prog_data opcode field, passed through combinationally to the ICU.
REQ-009 io_addr  out  PC_W  prog_data operand field, passed through combinationally for I/O selection.
REQ-010 jmp  in  1  jump request from the ICU.
REQ-011 rtn  in  1  return request from the ICU.
REQ-012 flag_f  in  1  NOPF flag from the ICU; arms a call.
REQ-013 depth  out  $clog2(STACK_DEPTH)+1  current number of stacked return addresses.
REQ-014 stack_err  out  1  sticky overflow/underflow indicator.

Function
REQ-015 Registers: PC, operand_q, call_armed, stack[STACK_DEPTH], depth, stack_err.
REQ-016 Each non-stalled edge: operand_q <= prog_data operand, captured before the PC update (it holds the operand of the word fetched at the old PC).
REQ-017 Next-PC priority per non-stalled edge: rtn > jmp > increment.
REQ-018 Increment: PC <= PC+1 modulo 2^PC_W; all-ones wraps to 0 with no flag.
REQ-019 jmp=1: PC <= operand_q (operand of the JMP word); exactly one delay slot, so the word fetched at the old PC+1 is presented once and executes.
REQ-020 jmp=1 with call_armed=1: push (PC+1) mod 2^PC_W, depth+1; call_armed <= 0.
REQ-021 jmp=1 with call_armed=0: plain jump, no push.
REQ-022 flag_f=1 (without jmp/rtn): call_armed <= 1; it stays armed until the next jmp or rtn.
REQ-023 rtn=1, depth>0: PC <= top-of-stack, depth-1, call_armed <= 0.
REQ-024 rtn=1, depth=0 (underflow): PC increments, stack_err <= 1, depth stays 0.
REQ-025 Push at depth=STACK_DEPTH (overflow): jump still taken, no entry written, depth unchanged, stack_err <= 1.
REQ-026 rtn and jmp both 1: rtn wins; jmp is ignored entirely (no push); call_armed <= 0.
REQ-027 stall=1 overrides jmp/rtn/flag_f; those requests are lost, not queued.
REQ-028 stack_err clears only on rst.
REQ-029 Stack entries are never read at an index >= depth; their contents are don't-care.

Reset
REQ-030 rst=1 at an edge: PC=0, operand_q=0, call_armed=0, depth=0, stack_err=0; overrides stall, jmp, rtn.
REQ-031 During and after reset, prog_addr=0; instruction and io_addr reflect the word at address 0.
REQ-032 Reset mid-call or mid-return discards the pending push/pop with no partial stack update.

Verification
REQ-033 Reset, memory all NOPO, 260 edges -> prog_addr counts 0..255, wraps to 0, ..., 3; stack_err=0.
REQ-034 Word at 0x10 = JMP with operand 0x40; assert jmp on the edge after PC reaches 0x11 -> PC sequence 0x10, 0x11, 0x40; depth=0.
REQ-035 flag_f pulse, then jmp with operand_q=0x80 at PC=0x21 -> push 0x22, depth=1, PC=0x80; later rtn -> PC=0x22, depth=0.
REQ-036 5 armed calls with STACK_DEPTH=4 -> depth saturates at 4, stack_err=1, fifth jump still lands on its target; 4 rtns return in LIFO order.
REQ-037 rtn at depth=0, PC=0x05 -> PC=0x06, stack_err=1 and stays 1 until rst.
REQ-038 stall held 3 edges with jmp=1 -> PC, depth and operand_q unchanged; rst asserted together with stall -> all registers reset.

Source files
------------

// File: rtl/program_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : program_sequencer
//  Description : Program counter with one-delay-slot jumps, armed calls
//                (NOPF flag followed by a jump) onto a return-address stack,
//                returns, a sticky stack-error flag and a global stall.
//  Revision    : 1.0 - initial release
// ============================================================================

package program_sequencer_pkg;
    typedef logic [3:0] instruction_t;
endpackage

module program_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    output logic [PC_W-1:0]                  prog_addr,
    input  logic [PC_W+3:0]                  prog_data,
    output program_sequencer_pkg::instruction_t instruction,
    output logic [PC_W-1:0]                  io_addr,
    input  logic                             jmp,
    input  logic                             rtn,
    input  logic                             flag_f,
    output logic [$clog2(STACK_DEPTH):0]     depth,
    output logic                             stack_err
);

    localparam int c_AW = $clog2(STACK_DEPTH);
    localparam int c_DW = c_AW + 1;

    localparam logic [c_DW-1:0] c_DEPTH_FULL = c_DW'(STACK_DEPTH);
    localparam logic [c_DW-1:0] c_DEPTH_ONE  = c_DW'(1);
    localparam logic [c_DW-1:0] c_DEPTH_ZERO = '0;
    localparam logic [c_AW-1:0] c_IDX_ONE    = c_AW'(1);
    localparam logic [PC_W-1:0] c_PC_ONE     = PC_W'(1);

    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_operand_q;
    logic            r_call_armed;
    logic [c_DW-1:0] r_depth;
    logic            r_stack_err;
    logic [PC_W-1:0] r_stack [STACK_DEPTH];

    logic [PC_W-1:0] w_operand;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_stack_full;
    logic            w_stack_empty;
    logic [c_AW-1:0] w_top_idx;
    logic [c_AW-1:0] w_push_idx;

    // Memory word split and stack pointer arithmetic
    always_comb begin
        w_operand     = prog_data[PC_W-1:0];
        w_pc_inc      = r_pc + c_PC_ONE;
        w_stack_full  = (r_depth == c_DEPTH_FULL);
        w_stack_empty = (r_depth == c_DEPTH_ZERO);
        // Low bits of depth address the entry being written next; the top
        // entry sits one below. Only meaningful when not full / not empty.
        w_push_idx    = r_depth[c_AW-1:0];
        w_top_idx     = r_depth[c_AW-1:0] - c_IDX_ONE;
    end

    assign prog_addr   = r_pc;
    assign instruction = prog_data[PC_W+3:PC_W];
    assign io_addr     = w_operand;
    assign depth       = r_depth;
    assign stack_err   = r_stack_err;

    // PC, operand capture, call arming and return-stack update
    always_ff @(posedge clk) begin
        if (rst) begin
            // Stack contents are left alone: entries above depth are don't-care
            r_pc         <= '0;
            r_operand_q  <= '0;
            r_call_armed <= 1'b0;
            r_depth      <= '0;
            r_stack_err  <= 1'b0;
        end else if (!stall) begin
            // Operand of the word at the old PC becomes the next jump target
            r_operand_q <= w_operand;
            if (rtn) begin
                // Return wins over a simultaneous jump, which is dropped
                r_call_armed <= 1'b0;
                if (w_stack_empty) begin
                    r_pc        <= w_pc_inc;
                    r_stack_err <= 1'b1;
                end else begin
                    r_pc    <= r_stack[w_top_idx];
                    r_depth <= r_depth - c_DEPTH_ONE;
                end
            end else if (jmp) begin
                r_pc         <= r_operand_q;
                r_call_armed <= 1'b0;
                if (r_call_armed) begin
                    if (w_stack_full) begin
                        // Overflow: jump still taken, return address lost
                        r_stack_err <= 1'b1;
                    end else begin
                        r_stack[w_push_idx] <= w_pc_inc;
                        r_depth             <= r_depth + c_DEPTH_ONE;
                    end
                end
            end else begin
                r_pc <= w_pc_inc;
                if (flag_f) begin
                    r_call_armed <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire
